// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe
//  Description : Pipelined RV32I/RV64I immediate generator. Decodes the
//                immediate format straight from the opcode, sign-extends (or,
//                for shift amounts, zero-extends) to XLEN, and buffers the
//                decoded result in a DEPTH-entry valid/ready output FIFO.
//                Optional push statistics are enabled by defining the macro
//                IMM_GEN_STATS_EN (adds acc_cnt_o / ill_cnt_o).
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [31:0]      instr_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [XLEN-1:0]  imm_o,
   output logic [2:0]       fmt_o,
   output logic             illegal_o
`ifdef IMM_GEN_STATS_EN
   ,
   output logic [CNT_W-1:0] acc_cnt_o,
   output logic [CNT_W-1:0] ill_cnt_o
`endif
);

   // Format codes presented on fmt_o
   localparam logic [2:0] c_FMT_I     = 3'd0;
   localparam logic [2:0] c_FMT_S     = 3'd1;
   localparam logic [2:0] c_FMT_B     = 3'd2;
   localparam logic [2:0] c_FMT_U     = 3'd3;
   localparam logic [2:0] c_FMT_J     = 3'd4;
   localparam logic [2:0] c_FMT_SHAMT = 3'd5;
   localparam logic [2:0] c_FMT_NONE  = 3'd7;

   // Major opcodes that carry an immediate
   localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OP_JALR   = 7'b1100111;
   localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] c_OP_STORE  = 7'b0100011;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OP_LUI    = 7'b0110111;
   localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_OP_JAL    = 7'b1101111;

   localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

   // Elaboration-time parameter legality checks
   if (XLEN != 32 && XLEN != 64) begin : g_chk_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
      $error("imm_gen_pipe: DEPTH must be a power of two, at least 2");
   end
   if (CNT_W < 1) begin : g_chk_cnt_w
      $error("imm_gen_pipe: CNT_W must be at least 1");
   end

   // ------------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------------
   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic [31:0]     w_raw;
   logic            w_sext;
   logic [2:0]      w_fmt;
   logic            w_ill;
   logic [XLEN-1:0] w_imm;

   assign w_opcode = instr_i[6:0];
   assign w_funct3 = instr_i[14:12];

   // Pick the immediate field layout from the opcode and extend it to XLEN
   always_comb begin
      w_raw  = 32'h0;
      w_sext = 1'b1;
      w_fmt  = c_FMT_NONE;
      w_ill  = 1'b1;
      case (w_opcode)
         c_OP_LOAD, c_OP_JALR: begin
            w_fmt = c_FMT_I;
            w_ill = 1'b0;
            w_raw = {{20{instr_i[31]}}, instr_i[31:20]};
         end
         c_OP_OPIMM: begin
            w_ill = 1'b0;
            if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
               // Shift amount: funct7 is not part of the value, never signed
               w_fmt  = c_FMT_SHAMT;
               w_sext = 1'b0;
               if (XLEN == 64) begin
                  w_raw = {26'h0, instr_i[25:20]};
               end else begin
                  w_raw = {27'h0, instr_i[24:20]};
               end
            end else begin
               w_fmt = c_FMT_I;
               w_raw = {{20{instr_i[31]}}, instr_i[31:20]};
            end
         end
         c_OP_STORE: begin
            w_fmt = c_FMT_S;
            w_ill = 1'b0;
            w_raw = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         end
         c_OP_BRANCH: begin
            w_fmt = c_FMT_B;
            w_ill = 1'b0;
            w_raw = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                     instr_i[30:25], instr_i[11:8], 1'b0};
         end
         c_OP_LUI, c_OP_AUIPC: begin
            w_fmt = c_FMT_U;
            w_ill = 1'b0;
            w_raw = {instr_i[31:12], 12'h000};
         end
         c_OP_JAL: begin
            w_fmt = c_FMT_J;
            w_ill = 1'b0;
            w_raw = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                     instr_i[20], instr_i[30:21], 1'b0};
         end
         default: begin
            w_fmt  = c_FMT_NONE;
            w_ill  = 1'b1;
            w_raw  = 32'h0;
            w_sext = 1'b0;
         end
      endcase
      // Upper bits (XLEN=64 only) replicate bit 31 for signed formats
      w_imm       = {XLEN{w_sext & w_raw[31]}};
      w_imm[31:0] = w_raw;
   end

   // ------------------------------------------------------------------------
   // Output FIFO
   // ------------------------------------------------------------------------
   logic [XLEN-1:0]    r_imm_mem [DEPTH];
   logic [2:0]         r_fmt_mem [DEPTH];
   logic               r_ill_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic               w_push;
   logic               w_pop;
   logic               w_empty;

   assign w_empty = (r_count == '0);
   // Readiness comes only from the registered count, so a pop in a full
   // cycle never opens the door for a same-cycle push.
   assign ready_o = (r_count != c_FULL);
   assign valid_o = ~w_empty;
   assign w_push  = valid_i & ready_o;
   assign w_pop   = valid_o & ready_i;

   // Store the already-decoded entry; entries are never re-decoded later
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_imm_mem[r_wr_ptr] <= w_imm;
         r_fmt_mem[r_wr_ptr] <= w_fmt;
         r_ill_mem[r_wr_ptr] <= w_ill;
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth)
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Present the head entry, or the idle values while the FIFO is empty
   always_comb begin
      imm_o     = '0;
      fmt_o     = c_FMT_NONE;
      illegal_o = 1'b0;
      if (!w_empty) begin
         imm_o     = r_imm_mem[r_rd_ptr];
         fmt_o     = r_fmt_mem[r_rd_ptr];
         illegal_o = r_ill_mem[r_rd_ptr];
      end
   end

`ifdef IMM_GEN_STATS_EN
   // ------------------------------------------------------------------------
   // Push statistics
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0] r_acc_cnt;
   logic [CNT_W-1:0] r_ill_cnt;

   // Saturating counters of accepted and illegal instructions
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_acc_cnt <= '0;
         r_ill_cnt <= '0;
      end else if (w_push) begin
         if (r_acc_cnt != '1) begin
            r_acc_cnt <= r_acc_cnt + CNT_W'(1);
         end
         if (w_ill && r_ill_cnt != '1) begin
            r_ill_cnt <= r_ill_cnt + CNT_W'(1);
         end
      end
   end

   assign acc_cnt_o = r_acc_cnt;
   assign ill_cnt_o = r_ill_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_gen_pipe
//  Description : Self-checking bench for imm_gen_pipe (XLEN=32/DEPTH=2 and
//                XLEN=64/DEPTH=4 instances). Uses IMM_GEN_STATS_EN if defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

   localparam int DEPTH = 2;
   localparam int CNT_W = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic        ready_i;
   logic [31:0] instr_i;
   logic        ready_o;
   logic        valid_o;
   logic [31:0] imm_o;
   logic [2:0]  fmt_o;
   logic        illegal_o;

   logic        rdy64;
   logic        ready64;
   logic        valid64;
   logic [63:0] imm64;
   logic [2:0]  fmt64;
   logic        ill64;

`ifdef IMM_GEN_STATS_EN
   logic [CNT_W-1:0] acc_cnt;
   logic [CNT_W-1:0] ill_cnt;
   logic [CNT_W-1:0] acc_cnt64;
   logic [CNT_W-1:0] ill_cnt64;
   int               exp_acc;
   int               exp_ill;
`endif

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .instr_i   (instr_i),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .imm_o     (imm_o),
      .fmt_o     (fmt_o),
      .illegal_o (illegal_o)
`ifdef IMM_GEN_STATS_EN
      ,
      .acc_cnt_o (acc_cnt),
      .ill_cnt_o (ill_cnt)
`endif
   );

   imm_gen_pipe #(.XLEN(64), .DEPTH(4), .CNT_W(CNT_W)) u_dut64 (
      .clk_i     (clk),
      .rst_i     (rst),
      .valid_i   (valid_i),
      .ready_o   (ready64),
      .instr_i   (instr_i),
      .valid_o   (valid64),
      .ready_i   (rdy64),
      .imm_o     (imm64),
      .fmt_o     (fmt64),
      .illegal_o (ill64)
`ifdef IMM_GEN_STATS_EN
      ,
      .acc_cnt_o (acc_cnt64),
      .ill_cnt_o (ill_cnt64)
`endif
   );

   typedef struct packed {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
   } ent_t;

   ent_t        q[$];
   int          n_asserts = 0;
   int          n_fails   = 0;
   logic        last_v;
   logic [31:0] last_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference decode straight from the ISA field definitions
   task automatic ref_dec(input logic [31:0] ins, input int xlen,
                          output logic [63:0] imm, output logic [2:0] fmt,
                          output logic ill);
      longint v;
      v   = 0;
      ill = 1'b0;
      fmt = 3'd7;
      case (ins[6:0])
         7'h03, 7'h67: begin fmt = 3'd0; v = longint'($signed(ins[31:20])); end
         7'h13: begin
            if (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) begin
               fmt = 3'd5;
               if (xlen == 64) v = longint'(ins[25:20]);
               else            v = longint'(ins[24:20]);
            end else begin
               fmt = 3'd0;
               v   = longint'($signed(ins[31:20]));
            end
         end
         7'h23: begin fmt = 3'd1; v = longint'($signed({ins[31:25], ins[11:7]})); end
         7'h63: begin
            fmt = 3'd2;
            v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
         end
         7'h37, 7'h17: begin fmt = 3'd3; v = longint'($signed({ins[31:12], 12'h000})); end
         7'h6F: begin
            fmt = 3'd4;
            v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
         end
         default: begin fmt = 3'd7; v = 0; ill = 1'b1; end
      endcase
      imm = (xlen == 32) ? {32'h0, v[31:0]} : 64'(v);
   endtask

   task automatic check_all();
      logic [63:0] e_imm;
      logic [2:0]  e_fmt;
      logic        e_ill;
      chk("valid_o", 64'(valid_o), 64'(q.size() != 0));
      chk("ready_o", 64'(ready_o), 64'(q.size() != DEPTH));
      if (q.size() == 0) begin
         chk("imm_o_idle", 64'(imm_o), 64'h0);
         chk("fmt_o_idle", 64'(fmt_o), 64'h7);
         chk("illegal_o_idle", 64'(illegal_o), 64'h0);
      end else begin
         chk("imm_o", 64'(imm_o), q[0].imm);
         chk("fmt_o", 64'(fmt_o), 64'(q[0].fmt));
         chk("illegal_o", 64'(illegal_o), 64'(q[0].ill));
      end
      chk("valid64", 64'(valid64), 64'(last_v));
      if (last_v) begin
         ref_dec(last_i, 64, e_imm, e_fmt, e_ill);
         chk("imm64", imm64, e_imm);
         chk("fmt64", 64'(fmt64), 64'(e_fmt));
         chk("ill64", 64'(ill64), 64'(e_ill));
      end
`ifdef IMM_GEN_STATS_EN
      chk("acc_cnt_o", 64'(acc_cnt), 64'(exp_acc));
      chk("ill_cnt_o", 64'(ill_cnt), 64'(exp_ill));
`endif
   endtask

   // One clock: drive at negedge, update model at posedge, check at next negedge
   task automatic step(input logic v, input logic [31:0] ins, input logic r);
      logic push;
      logic pop;
      ent_t e;
      valid_i = v;
      instr_i = ins;
      ready_i = r;
      push = v && (q.size() < DEPTH);
      pop  = (q.size() > 0) && r;
      @(posedge clk);
      ref_dec(ins, 32, e.imm, e.fmt, e.ill);
      if (pop) void'(q.pop_front());
      if (push) begin
         q.push_back(e);
`ifdef IMM_GEN_STATS_EN
         exp_acc++;
         if (e.ill) exp_ill++;
`endif
      end
      last_v = v;
      last_i = ins;
      @(negedge clk);
      check_all();
   endtask

   task automatic chk_head(input string tag, input logic [31:0] eimm,
                           input logic [2:0] efmt, input logic eill);
      chk({tag, "_valid"}, 64'(valid_o), 64'h1);
      chk({tag, "_imm"}, 64'(imm_o), 64'(eimm));
      chk({tag, "_fmt"}, 64'(fmt_o), 64'(efmt));
      chk({tag, "_ill"}, 64'(illegal_o), 64'(eill));
   endtask

   logic [6:0] ops [10];

   initial begin
      ops = '{7'h03, 7'h67, 7'h13, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h13};
      rst     = 1'b1;
      valid_i = 1'b0;
      ready_i = 1'b0;
      instr_i = 32'h0;
      rdy64   = 1'b1;
      last_v  = 1'b0;
      last_i  = 32'h0;
`ifdef IMM_GEN_STATS_EN
      exp_acc = 0;
      exp_ill = 0;
`endif
      repeat (2) @(negedge clk);
      check_all();
      rst = 1'b0;
      @(negedge clk);
      check_all();

      // Directed formats, back to back with consumer ready
      step(1'b1, 32'hFFF00093, 1'b1);
      chk_head("addi", 32'hFFFFFFFF, 3'd0, 1'b0);
      chk("addi_imm64", imm64, 64'hFFFFFFFF_FFFFFFFF);
      step(1'b1, 32'hFE112E23, 1'b1);
      chk_head("sw", 32'hFFFFFFFC, 3'd1, 1'b0);
      step(1'b1, 32'hFE000CE3, 1'b1);
      chk_head("beq", 32'hFFFFFFF8, 3'd2, 1'b0);
      step(1'b1, 32'h123452B7, 1'b1);
      chk_head("lui", 32'h12345000, 3'd3, 1'b0);
      step(1'b1, 32'h4030D093, 1'b1);
      chk_head("srai", 32'h00000003, 3'd5, 1'b0);
      chk("srai_imm64", imm64, 64'h3);
      step(1'b1, 32'hFFDFF06F, 1'b1);
      chk_head("jal", 32'hFFFFFFFC, 3'd4, 1'b0);
      step(1'b1, 32'h00000000, 1'b1);
      chk_head("illegal", 32'h0, 3'd7, 1'b1);
      step(1'b0, 32'h0, 1'b1);

      // Backpressure: third instruction held until space frees
      step(1'b1, 32'h00500093, 1'b0);
      step(1'b1, 32'h123452B7, 1'b0);
      chk("full_ready_o", 64'(ready_o), 64'h0);
      step(1'b1, 32'hFFDFF06F, 1'b0);
      chk("held_ready_o", 64'(ready_o), 64'h0);
      chk_head("bp_first", 32'h00000005, 3'd0, 1'b0);
      step(1'b1, 32'hFFDFF06F, 1'b1);
      chk("after_pop_ready_o", 64'(ready_o), 64'h1);
      chk_head("bp_second", 32'h12345000, 3'd3, 1'b0);
      step(1'b1, 32'hFFDFF06F, 1'b1);
      chk_head("bp_third", 32'hFFFFFFFC, 3'd4, 1'b0);
      step(1'b0, 32'h0, 1'b1);

      // Randomised traffic against the queue model
      for (int k = 0; k < 400; k++) begin
         logic [31:0] ins;
         int          pick;
         ins  = $urandom;
         pick = $urandom_range(0, 11);
         if (pick < 10) ins[6:0] = ops[pick];
         step($urandom_range(0, 3) != 0, ins, $urandom_range(0, 2) != 0);
      end
      repeat (3) step(1'b0, 32'h0, 1'b1);

      // Reset in the middle of a cycle with a full FIFO
      step(1'b1, 32'hFFF00093, 1'b0);
      step(1'b1, 32'hFE112E23, 1'b0);
      #2;
      rst = 1'b1;
      q.delete();
      last_v = 1'b0;
`ifdef IMM_GEN_STATS_EN
      exp_acc = 0;
      exp_ill = 0;
`endif
      #1;
      chk("rst_valid_o", 64'(valid_o), 64'h0);
      chk("rst_ready_o", 64'(ready_o), 64'h1);
      check_all();
      @(negedge clk);
      valid_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 32'h123452B7, 1'b1);
      chk_head("post_rst_lui", 32'h12345000, 3'd3, 1'b0);
      step(1'b0, 32'h0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the RV32I/RV64I datapath; the successor to the combinational sign-extend unit.
- Decodes the format (I/S/B/U/J plus shift-immediate) from the opcode itself instead of from control strobes, and sign-extends to XLEN.
- Result is buffered in a DEPTH-entry output FIFO with valid/ready handshakes on both sides.
- Sits between the IF/ID register and the ID/EX operand mux.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- DEPTH, 2, output FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- valid_i  input  1  instr_i carries a valid instruction.
- ready_o  output  1  block can accept an instruction this cycle.
- instr_i  input  32  raw instruction word.
- valid_o  output  1  head FIFO entry is valid.
- ready_i  input  1  consumer accepts the head entry.
- imm_o  output  XLEN  sign- or zero-extended immediate.
- fmt_o  output  3  format code: 0=I, 1=S, 2=B, 3=U, 4=J, 5=SHAMT, 7=NONE.
- illegal_o  output  1  opcode not recognised.

Behaviour:
- Reset (async assert, sync release): FIFO empty; pointers and count = 0; valid_o=0; imm_o=0; fmt_o=7; illegal_o=0; ready_o=1.
- Push occurs when valid_i && ready_o. Pop occurs when valid_o && ready_i.
- ready_o = (count != DEPTH). It depends only on registered count; there is no combinational path from ready_i.
  - When full, a same-cycle pop does not permit a push.
- Latency: an instruction pushed in cycle N is visible at the outputs in cycle N+1 when the FIFO was empty.
- Outputs are driven from the head entry. When empty, they hold the reset values.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Ordering is strict FIFO. valid_i while ready_o=0 is ignored; the producer must hold.
- Opcode decode on instr_i[6:0]:
  - 0000011, 1100111: I.
  - 0010011: I, except funct3 001/101, which is SHAMT.
  - 0100011: S.
  - 1100011: B.
  - 0110111, 0010111: U.
  - 1101111: J.
  - Anything else: fmt 7, imm 0, illegal 1.
- Immediate construction, with bit 31 replicated up to XLEN-1:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- SHAMT immediate is zero-extended, never sign-extended; funct7 is excluded.
  - Field is instr[24:20] when XLEN=32.
  - Field is instr[25:20] when XLEN=64.
- Decode happens before the FIFO write. Stored entries are never re-decoded.
- Reset mid-stream discards all entries. The first push after release is the next valid_o.

Optional Feature:
- Macro: IMM_GEN_STATS_EN.
- When defined, two added outputs exist, both 0 at reset:
  - acc_cnt_o [CNT_W-1:0]: counts pushes.
  - ill_cnt_o [CNT_W-1:0]: counts pushes with illegal decode.
  - Both counters saturate at all-ones and do not wrap.
- When undefined, these ports and the counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then push 0xFFF00093 (addi -1) with ready_i=1 -> next cycle valid_o=1, imm_o=0xFFFFFFFF, fmt_o=0, illegal_o=0.
- Push 0xFE112E23 (sw -4), 0xFE000CE3 (beq -8), 0x123452B7 (lui) back to back -> imm_o = 0xFFFFFFFC/S, 0xFFFFFFF8/B, 0x12345000/U on consecutive cycles.
- Push 0x4030D093 (srai 3) -> imm_o=0x00000003, fmt_o=5. With XLEN=64, 0xFFF00093 -> imm_o=0xFFFFFFFFFFFFFFFF.
- Hold ready_i=0, push 3 instructions with DEPTH=2 -> ready_o=0 after 2 pushes and the third is held. Raise ready_i -> all 3 emerge in order, and ready_o returns to 1 the cycle after the first pop.
- Push 0x00000000 -> illegal_o=1, imm_o=0, fmt_o=7. With IMM_GEN_STATS_EN, ill_cnt_o=1 and acc_cnt_o increments.
- Fill the FIFO, assert rst_i mid-cycle -> valid_o=0 immediately and ready_o=1. After release, a push of 0x123452B7 yields 0x12345000 as the first output.
